// File: rtl/dbg_sba_axi_pkg.sv
// Shared types and constants for the debug system-bus to AXI4 bridge.
package dbg_sba_axi_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StWrResp,
    StRdReq,
    StRdResp,
    StDone,
    StDrain
  } state_e;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;

  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [3:0] CacheModifiable = 4'b0010;

  // AXI size encoding is log2 of the beat size in bytes.
  function automatic logic [2:0] size_from_bytes(input int unsigned bytes);
    logic [2:0] size;
    size = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if ((32'd1 << i) == bytes) size = 3'(i);
    end
    return size;
  endfunction

endpackage

// File: rtl/dbg_sba_axi_bridge_if.sv
// AXI4 bus bundle used on the bridge master port.
interface dbg_sba_axi_bridge_if #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_USER_WIDTH = 1
);
  logic [AXI_ID_WIDTH-1:0]     aw_id;
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]                  aw_len;
  logic [2:0]                  aw_size;
  logic [1:0]                  aw_burst;
  logic                        aw_lock;
  logic [3:0]                  aw_cache;
  logic [2:0]                  aw_prot;
  logic [3:0]                  aw_qos;
  logic [3:0]                  aw_region;
  logic [5:0]                  aw_atop;
  logic [AXI_USER_WIDTH-1:0]   aw_user;
  logic                        aw_valid;
  logic                        aw_ready;

  logic [AXI_DATA_WIDTH-1:0]   w_data;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb;
  logic                        w_last;
  logic [AXI_USER_WIDTH-1:0]   w_user;
  logic                        w_valid;
  logic                        w_ready;

  logic [AXI_ID_WIDTH-1:0]     b_id;
  logic [1:0]                  b_resp;
  logic [AXI_USER_WIDTH-1:0]   b_user;
  logic                        b_valid;
  logic                        b_ready;

  logic [AXI_ID_WIDTH-1:0]     ar_id;
  logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]                  ar_len;
  logic [2:0]                  ar_size;
  logic [1:0]                  ar_burst;
  logic                        ar_lock;
  logic [3:0]                  ar_cache;
  logic [2:0]                  ar_prot;
  logic [3:0]                  ar_qos;
  logic [3:0]                  ar_region;
  logic [AXI_USER_WIDTH-1:0]   ar_user;
  logic                        ar_valid;
  logic                        ar_ready;

  logic [AXI_ID_WIDTH-1:0]     r_id;
  logic [AXI_DATA_WIDTH-1:0]   r_data;
  logic [1:0]                  r_resp;
  logic                        r_last;
  logic [AXI_USER_WIDTH-1:0]   r_user;
  logic                        r_valid;
  logic                        r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
           aw_region, aw_atop, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
           ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
           aw_region, aw_atop, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
           ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/dbg_sba_lane_steer.sv
// Maps a narrow bus beat onto one lane of a wider AXI data bus and back.
module dbg_sba_lane_steer #(
  parameter int unsigned BUS_WIDTH      = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  localparam int unsigned NumLanes = AXI_DATA_WIDTH / BUS_WIDTH,
  localparam int unsigned LaneW    = (NumLanes > 1) ? $clog2(NumLanes) : 1,
  localparam int unsigned StrbW    = AXI_DATA_WIDTH / 8
) (
  input  logic [LaneW-1:0]          lane,
  input  logic [BUS_WIDTH-1:0]      wdata,
  input  logic [BUS_WIDTH/8-1:0]    be,
  input  logic [AXI_DATA_WIDTH-1:0] axi_rdata,
  output logic [AXI_DATA_WIDTH-1:0] axi_wdata,
  output logic [StrbW-1:0]          axi_wstrb,
  output logic [BUS_WIDTH-1:0]      rdata
);

  always_comb begin
    axi_wdata = '0;
    for (int unsigned i = 0; i < NumLanes; i++) begin
      axi_wdata[i*BUS_WIDTH +: BUS_WIDTH] = wdata;
    end
  end

  assign axi_wstrb = StrbW'(be) << (lane * (BUS_WIDTH / 8));
  assign rdata     = axi_rdata[lane*BUS_WIDTH +: BUS_WIDTH];

endmodule

// File: rtl/dbg_sba_axi_bridge.sv
// Debug system-bus (req/gnt/rvalid) to AXI4 master bridge, one transaction in flight,
// with lane steering, error propagation and a draining timeout.
module dbg_sba_axi_bridge
  import dbg_sba_axi_pkg::*;
#(
  parameter int unsigned BUS_WIDTH      = 32,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_USER_WIDTH = 1,
  parameter int unsigned AXI_ID         = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_i,
  input  logic [BUS_WIDTH-1:0]   add_i,
  input  logic                   we_i,
  input  logic [BUS_WIDTH-1:0]   wdata_i,
  input  logic [BUS_WIDTH/8-1:0] be_i,
  output logic                   gnt_o,
  output logic                   r_valid_o,
  output logic [BUS_WIDTH-1:0]   r_rdata_o,
  output logic                   r_err_o,
  output logic                   r_other_err_o,
  output logic                   busy_o,
  dbg_sba_axi_bridge_if.master   master
);

  localparam int unsigned BusBytes = BUS_WIDTH / 8;
  localparam int unsigned AxiBytes = AXI_DATA_WIDTH / 8;
  localparam int unsigned NumLanes = AXI_DATA_WIDTH / BUS_WIDTH;
  localparam int unsigned LaneW    = (NumLanes > 1) ? $clog2(NumLanes) : 1;
  localparam int unsigned CntW     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

  state_e                 state_q, state_d;
  logic [BUS_WIDTH-1:0]   addr_q, wdata_q, rdata_q;
  logic [BUS_WIDTH/8-1:0] be_q;
  logic                   we_q, err_q;
  logic                   aw_done_q, w_done_q, ar_done_q;
  logic [CntW-1:0]        cnt_q;

  logic aw_valid, w_valid, ar_valid, b_ready, r_ready;
  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic counting, timeout_hit;
  logic [LaneW-1:0]          lane;
  logic [BUS_WIDTH-1:0]      addr_aligned, steered_rdata;
  logic [AXI_ADDR_WIDTH-1:0] ax_addr;

  if (NumLanes > 1) begin : g_lane
    assign lane = addr_q[$clog2(AxiBytes)-1:$clog2(BusBytes)];
  end else begin : g_no_lane
    assign lane = '0;
  end

  assign addr_aligned = addr_q & ~BUS_WIDTH'(BusBytes - 1);
  assign ax_addr      = AXI_ADDR_WIDTH'(addr_aligned);

  dbg_sba_lane_steer #(
    .BUS_WIDTH      (BUS_WIDTH),
    .AXI_DATA_WIDTH (AXI_DATA_WIDTH)
  ) u_lane_steer (
    .lane      (lane),
    .wdata     (wdata_q),
    .be        (be_q),
    .axi_rdata (master.r_data),
    .axi_wdata (master.w_data),
    .axi_wstrb (master.w_strb),
    .rdata     (steered_rdata)
  );

  assign counting = (state_q == StWrReq) || (state_q == StWrResp) ||
                    (state_q == StRdReq) || (state_q == StRdResp);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && counting && (cnt_q == CntMax);

  // Channel controls; DRAIN keeps finishing whatever the aborted transaction left open.
  always_comb begin
    aw_valid = ((state_q == StWrReq) || (state_q == StDrain && we_q)) && !aw_done_q;
    w_valid  = ((state_q == StWrReq) || (state_q == StDrain && we_q)) && !w_done_q;
    ar_valid = ((state_q == StRdReq) || (state_q == StDrain && !we_q)) && !ar_done_q;
    b_ready  = (state_q == StWrResp) || (state_q == StDrain && we_q);
    r_ready  = (state_q == StRdResp) || (state_q == StDrain && !we_q);
  end

  assign aw_hs = aw_valid && master.aw_ready;
  assign w_hs  = w_valid && master.w_ready;
  assign ar_hs = ar_valid && master.ar_ready;
  assign b_hs  = b_ready && master.b_valid;
  assign r_hs  = r_ready && master.r_valid;

  always_comb begin
    gnt_o         = req_i && (state_q == StIdle) && !rst;
    busy_o        = (state_q != StIdle);
    r_valid_o     = (state_q == StDone) || timeout_hit;
    r_other_err_o = timeout_hit;
    r_err_o       = (state_q == StDone) && err_q;
    r_rdata_o     = (state_q == StDone) ? rdata_q : '0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (gnt_o) state_d = we_i ? StWrReq : StRdReq;
      StWrReq: begin
        if (timeout_hit) state_d = StDrain;
        else if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = StWrResp;
      end
      StWrResp: begin
        // A response landing on the timeout cycle is consumed, so nothing is left to drain.
        if (timeout_hit) state_d = b_hs ? StIdle : StDrain;
        else if (b_hs) state_d = StDone;
      end
      StRdReq: begin
        if (timeout_hit) state_d = StDrain;
        else if (ar_hs) state_d = StRdResp;
      end
      StRdResp: begin
        if (timeout_hit) state_d = r_hs ? StIdle : StDrain;
        else if (r_hs) state_d = StDone;
      end
      StDone:   state_d = StIdle;
      StDrain:  if ((we_q && b_hs) || (!we_q && r_hs)) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      we_q      <= 1'b0;
      cnt_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      ar_done_q <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (gnt_o) begin
        addr_q    <= add_i;
        we_q      <= we_i;
        wdata_q   <= wdata_i;
        be_q      <= be_i;
        cnt_q     <= '0;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
        ar_done_q <= 1'b0;
      end else begin
        if (counting && cnt_q != CntMax) cnt_q <= cnt_q + 1'b1;
        if (aw_hs) aw_done_q <= 1'b1;
        if (w_hs)  w_done_q  <= 1'b1;
        if (ar_hs) ar_done_q <= 1'b1;
      end
      if (state_q == StWrResp && b_hs && !timeout_hit) begin
        err_q   <= master.b_resp[1];
        rdata_q <= '0;
      end
      if (state_q == StRdResp && r_hs && !timeout_hit) begin
        err_q   <= master.r_resp[1];
        rdata_q <= steered_rdata;
      end
    end
  end

  assign master.aw_id     = AXI_ID_WIDTH'(AXI_ID);
  assign master.aw_addr   = ax_addr;
  assign master.aw_len    = 8'd0;
  assign master.aw_size   = size_from_bytes(BusBytes);
  assign master.aw_burst  = BurstIncr;
  assign master.aw_lock   = 1'b0;
  assign master.aw_cache  = CacheModifiable;
  assign master.aw_prot   = 3'b000;
  assign master.aw_qos    = 4'd0;
  assign master.aw_region = 4'd0;
  assign master.aw_atop   = 6'd0;
  assign master.aw_user   = '0;
  assign master.aw_valid  = aw_valid;
  assign master.w_last    = 1'b1;
  assign master.w_user    = '0;
  assign master.w_valid   = w_valid;
  assign master.b_ready   = b_ready;
  assign master.ar_id     = AXI_ID_WIDTH'(AXI_ID);
  assign master.ar_addr   = ax_addr;
  assign master.ar_len    = 8'd0;
  assign master.ar_size   = size_from_bytes(BusBytes);
  assign master.ar_burst  = BurstIncr;
  assign master.ar_lock   = 1'b0;
  assign master.ar_cache  = CacheModifiable;
  assign master.ar_prot   = 3'b000;
  assign master.ar_qos    = 4'd0;
  assign master.ar_region = 4'd0;
  assign master.ar_user   = '0;
  assign master.ar_valid  = ar_valid;
  assign master.r_ready   = r_ready;

  logic unused_sig;
  assign unused_sig = ^{master.b_id, master.b_user, master.b_resp[0], master.r_id,
                        master.r_last, master.r_user, master.r_resp[0]};

endmodule
